ramp_driver: RTL and testbench
==============================

Name: ramp_driver

Overview:
Sweep controller that drives the enable, step-strobe and step-select inputs of the 12-bit Ramp generator. One start request runs one full-scale sweep. The block issues timed delta strobes and tracks a shadow copy of the Ramp output. It stops at the last step that does not exceed 4095, so the Ramp never wraps. It sits between the pattern sequencer and the Ramp.

Parameters:
PERIOD_W, 16, width of the step-interval input
MAX_LEVEL, 4095, full-scale limit; no step may take the level above this value

Ports:
clk  input  1  master clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle sweep request; ignored while busy=1
abort  input  1  stop immediately and return to idle; has priority over start
y_sel  input  2  step code: 00=0, 01=1, 10=16, 11=1290; sampled only when start is accepted
period  input  PERIOD_W  idle cycles between strobes; sampled only when start is accepted
ramp_enb  output  1  to Ramp ramp_enb
delta  output  1  to Ramp delta; one-cycle strobe per step
Y  output  2  to Ramp Y; latched y_sel, held for the whole sweep
level  output  12  shadow of the Ramp output
step_cnt  output  12  number of delta strobes issued in the current sweep
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- All outputs are registered.
- Reset values: ramp_enb=0, delta=0, Y=00, level=0, step_cnt=0, busy=0, done=0; state=IDLE.
- States: IDLE, CLEAR, ARM, WAIT, STEP, HOLD.
- IDLE:
  - ramp_enb=0, delta=0.
  - On start with abort=0: latch y_sel into Y, latch period; clear level and step_cnt; set busy=1; go to ARM.
- CLEAR:
  - Entered on start from HOLD.
  - Drives ramp_enb=0 for exactly one cycle so the Ramp clears to 0.
  - Latches inputs and clears counters exactly as in IDLE; then goes to ARM.
- ARM:
  - ramp_enb=1 for one cycle with no strobe.
  - Load interval timer with the latched period.
  - If Y=00: assert done and go to HOLD (zero-step sweep, step_cnt=0).
  - Otherwise go to WAIT.
- WAIT:
  - Timer decrements by 1 per cycle.
  - When timer=0, evaluate the projected level (level plus any strobe not yet absorbed by level) + deltaY.
  - If the result is <= MAX_LEVEL, go to STEP.
  - Otherwise go to HOLD.
  - With period=0, WAIT lasts one cycle.
- STEP:
  - delta=1 for exactly one cycle; step_cnt increments on the same edge.
  - Reload the timer with period; return to WAIT.
  - Strobe spacing is therefore period+1 cycles, rising edge to rising edge.
  - Exception: period=0 gives back-to-back strobes, so delta stays high continuously.
- level tracking:
  - level += deltaY on every clock edge where the registered delta=1 and ramp_enb=1.
  - level therefore equals the Ramp output on every cycle.
- done:
  - One-cycle pulse on the edge where level takes its final value.
  - busy falls on the same edge.
  - Entering HOLD happens only once no strobes are outstanding.
- HOLD:
  - ramp_enb stays 1 so the Ramp holds its final value; delta=0; busy=0.
  - On start, go to CLEAR.
- abort:
  - Allowed in any state; go to IDLE on the next edge.
  - ramp_enb, delta and busy drop to 0; level drops to 0, matching the Ramp clear.
  - step_cnt freezes at its current value; no done pulse.
- Widths:
  - deltaY is an 11-bit constant.
  - The projected-level comparison uses 13-bit arithmetic, so no wrap is possible.
- Final sweep values:
  - Y=01: level=4095, step_cnt=4095.
  - Y=10: level=4080, step_cnt=255.
  - Y=11: level=3870, step_cnt=3.
- A start arriving while busy=1 is dropped with no queuing. A start in the same cycle as abort is dropped.
- Reset asserted mid-sweep forces the reset values immediately (asynchronous).

Test Plan:
- Reset, then start with y_sel=11, period=2 -> ramp_enb rises; three delta pulses spaced 3 cycles apart; level steps 1290, 2580, 3870; done pulses once with step_cnt=3; ramp_enb stays 1.
- start with y_sel=10, period=0 -> delta high for 255 consecutive cycles; level 4080 and done on the edge after the last strobe; level never exceeds 4095.
- start with y_sel=01, period=0 -> final level=4095, step_cnt=4095, exactly one done pulse.
- start with y_sel=00 -> no delta strobes; done two cycles after start; level=0.
- Mid-sweep (y_sel=10, level=160) assert abort -> next cycle ramp_enb=0, delta=0, busy=0, level=0, no done. Repeat with start and abort in the same cycle -> sweep not started.
- From HOLD after a y_sel=11 sweep, start with y_sel=10 -> exactly one cycle of ramp_enb=0 (CLEAR), then a new sweep from 0. A start pulse during busy -> no effect. Assert rst_n=0 mid-strobe -> all outputs 0 immediately.

Source files
------------

// File: rtl/ramp_driver_if.sv
// rtl/ramp_driver_if.sv - sequencer-side request and Ramp-side drive bundle for ramp_driver
interface ramp_driver_if #(
   parameter int PERIOD_W = 16
);
   logic                start;
   logic                abort;
   logic [1:0]          y_sel;
   logic [PERIOD_W-1:0] period;
   logic                ramp_enb;
   logic                delta;
   logic [1:0]          Y;
   logic [11:0]         level;
   logic [11:0]         step_cnt;
   logic                busy;
   logic                done;

   modport master (
      output start, abort, y_sel, period,
      input  ramp_enb, delta, Y, level, step_cnt, busy, done
   );

   modport slave (
      input  start, abort, y_sel, period,
      output ramp_enb, delta, Y, level, step_cnt, busy, done
   );
endinterface

// File: rtl/ramp_driver.sv
// rtl/ramp_driver.sv - full-scale sweep controller for the 12-bit Ramp generator
module ramp_driver #(
   parameter int PERIOD_W  = 16,
   parameter int MAX_LEVEL = 4095
) (
   input logic         clk,
   input logic         rst_n,
   ramp_driver_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, ARM, WAIT, STEP, HOLD} state_t;

   state_t              state;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] timer;
   logic                ramp_enb_q;
   logic                delta_q;
   logic [1:0]          y_q;
   logic [11:0]         level_q;
   logic [11:0]         step_cnt_q;
   logic                busy_q;
   logic                done_q;

   logic [10:0]         dy;
   logic [12:0]         proj;
   logic                fits;

   // Projection counts a strobe still on the wire, so a decision taken in STEP
   // looks one step past the level the Ramp will reach on this edge.
   always_comb begin
      case (y_q)
         2'b00:   dy = 11'd0;
         2'b01:   dy = 11'd1;
         2'b10:   dy = 11'd16;
         default: dy = 11'd1290;
      endcase
      proj = {1'b0, level_q} + {2'b00, dy} + (delta_q ? {2'b00, dy} : 13'd0);
      fits = (proj <= 13'(MAX_LEVEL));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         period_q   <= '0;
         timer      <= '0;
         ramp_enb_q <= 1'b0;
         delta_q    <= 1'b0;
         y_q        <= 2'b00;
         level_q    <= 12'd0;
         step_cnt_q <= 12'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (delta_q && ramp_enb_q)
            level_q <= level_q + {1'b0, dy};

         if (bus.abort) begin
            state      <= IDLE;
            ramp_enb_q <= 1'b0;
            delta_q    <= 1'b0;
            busy_q     <= 1'b0;
            level_q    <= 12'd0;
         end else begin
            case (state)
               IDLE: begin
                  ramp_enb_q <= 1'b0;
                  delta_q    <= 1'b0;
                  if (bus.start) begin
                     y_q        <= bus.y_sel;
                     period_q   <= bus.period;
                     level_q    <= 12'd0;
                     step_cnt_q <= 12'd0;
                     busy_q     <= 1'b1;
                     ramp_enb_q <= 1'b1;
                     state      <= ARM;
                  end
               end
               CLEAR: begin
                  level_q    <= 12'd0;
                  ramp_enb_q <= 1'b1;
                  state      <= ARM;
               end
               ARM: begin
                  timer <= period_q;
                  if (y_q == 2'b00) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= HOLD;
                  end else begin
                     state <= WAIT;
                  end
               end
               WAIT: begin
                  if (timer == '0) begin
                     if (fits) begin
                        delta_q    <= 1'b1;
                        step_cnt_q <= step_cnt_q + 12'd1;
                        state      <= STEP;
                     end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= HOLD;
                     end
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               STEP: begin
                  // The STEP cycle is the first idle cycle of the next interval.
                  if (!fits) begin
                     delta_q <= 1'b0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state   <= HOLD;
                  end else if (period_q == '0) begin
                     delta_q    <= 1'b1;
                     step_cnt_q <= step_cnt_q + 12'd1;
                  end else begin
                     delta_q <= 1'b0;
                     timer   <= period_q - 1'b1;
                     state   <= WAIT;
                  end
               end
               HOLD: begin
                  delta_q <= 1'b0;
                  if (bus.start) begin
                     y_q        <= bus.y_sel;
                     period_q   <= bus.period;
                     step_cnt_q <= 12'd0;
                     busy_q     <= 1'b1;
                     ramp_enb_q <= 1'b0;
                     state      <= CLEAR;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.ramp_enb = ramp_enb_q;
   assign bus.delta    = delta_q;
   assign bus.Y        = y_q;
   assign bus.level    = level_q;
   assign bus.step_cnt = step_cnt_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_ramp_driver.sv
// tb/tb_ramp_driver.sv - directed vector bench for ramp_driver
module tb_ramp_driver;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   ramp_driver_if #(.PERIOD_W(16)) bus ();

   ramp_driver #(.PERIOD_W(16), .MAX_LEVEL(4095)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [1:0]  ys;
      logic [15:0] per;
      logic        enb;
      logic        dl;
      logic [11:0] lv;
      logic        lv_chk;
      logic [11:0] cnt;
      logic        bsy;
      logic        dn;
   } vec_t;

   vec_t vt [17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic track_sweep(input int dy, input int lv0, input bit d0,
                              input int exp_steps, input int exp_level);
      int model, run, gaps, lverr, dn;
      bit prevd;
      model = lv0; prevd = d0; run = int'(d0); gaps = 0; lverr = 0; dn = 0;
      for (int c = 0; c < 5000; c++) begin
         tick();
         if (prevd) model += dy;
         if (int'(bus.level) != model) lverr++;
         if (bus.delta) run++;
         else if (run > 0 && !bus.done) gaps++;
         prevd = bus.delta;
         if (bus.done) begin
            dn = 1;
            break;
         end
      end
      chk("sweep_done_seen", dn, 1);
      chk("sweep_strobe_run", run, exp_steps);
      chk("sweep_strobe_gaps", gaps, 0);
      chk("sweep_level_track", lverr, 0);
      chk("sweep_final_level", int'(bus.level), exp_level);
      chk("sweep_final_cnt", int'(bus.step_cnt), exp_steps);
      chk("sweep_busy_at_done", int'(bus.busy), 0);
      tick();
      chk("sweep_done_once", int'(bus.done), 0);
      chk("sweep_hold_enb", int'(bus.ramp_enb), 1);
      chk("sweep_hold_delta", int'(bus.delta), 0);
      chk("sweep_hold_level", int'(bus.level), exp_level);
   endtask

   initial begin
      int found, dn_seen, d_seen;
      n_cmp = 0; n_fail = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.y_sel = 2'b00; bus.period = 16'd0;

      // st ys per | enb dl lv lv_chk cnt bsy dn
      vt[0]  = '{1'b1, 2'b11, 16'd2, 1'b1, 1'b0, 12'd0,    1'b1, 12'd0, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd0,    1'b1, 12'd0, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd0,    1'b1, 12'd0, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd0,    1'b1, 12'd0, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b1, 12'd0,    1'b1, 12'd1, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd1290, 1'b1, 12'd1, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 2'b01, 16'd0, 1'b1, 1'b0, 12'd1290, 1'b1, 12'd1, 1'b1, 1'b0};
      vt[7]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b1, 12'd1290, 1'b1, 12'd2, 1'b1, 1'b0};
      vt[8]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd2580, 1'b1, 12'd2, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd2580, 1'b1, 12'd2, 1'b1, 1'b0};
      vt[10] = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b1, 12'd2580, 1'b1, 12'd3, 1'b1, 1'b0};
      vt[11] = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd3870, 1'b1, 12'd3, 1'b0, 1'b1};
      vt[12] = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd3870, 1'b1, 12'd3, 1'b0, 1'b0};
      vt[13] = '{1'b1, 2'b10, 16'd0, 1'b0, 1'b0, 12'd0,    1'b0, 12'd0, 1'b1, 1'b0};
      vt[14] = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd0,    1'b1, 12'd0, 1'b1, 1'b0};
      vt[15] = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b0, 12'd0,    1'b1, 12'd0, 1'b1, 1'b0};
      vt[16] = '{1'b0, 2'b00, 16'd0, 1'b1, 1'b1, 12'd0,    1'b1, 12'd1, 1'b1, 1'b0};

      repeat (2) tick();
      chk("rst_enb", int'(bus.ramp_enb), 0);
      chk("rst_delta", int'(bus.delta), 0);
      chk("rst_Y", int'(bus.Y), 0);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_cnt", int'(bus.step_cnt), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", int'(bus.busy), 0);

      // y=11 period=2 sweep, a dropped start while busy, then restart from HOLD
      for (int i = 0; i < 17; i++) begin
         bus.start = vt[i].st; bus.y_sel = vt[i].ys; bus.period = vt[i].per;
         tick();
         chk($sformatf("v%0d_enb", i), int'(bus.ramp_enb), int'(vt[i].enb));
         chk($sformatf("v%0d_delta", i), int'(bus.delta), int'(vt[i].dl));
         if (vt[i].lv_chk) chk($sformatf("v%0d_level", i), int'(bus.level), int'(vt[i].lv));
         chk($sformatf("v%0d_cnt", i), int'(bus.step_cnt), int'(vt[i].cnt));
         chk($sformatf("v%0d_busy", i), int'(bus.busy), int'(vt[i].bsy));
         chk($sformatf("v%0d_done", i), int'(bus.done), int'(vt[i].dn));
      end
      bus.start = 1'b0;

      // remainder of the y=10 period=0 sweep: 255 back-to-back strobes
      track_sweep(16, 0, 1'b1, 255, 4080);

      // y=01 period=0 from HOLD
      bus.start = 1'b1; bus.y_sel = 2'b01; bus.period = 16'd0;
      tick();
      bus.start = 1'b0;
      chk("clear_enb", int'(bus.ramp_enb), 0);
      tick();
      chk("arm_level", int'(bus.level), 0);
      track_sweep(1, 0, 1'b0, 4095, 4095);

      // abort from HOLD
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("ab_hold_enb", int'(bus.ramp_enb), 0);
      chk("ab_hold_level", int'(bus.level), 0);
      chk("ab_hold_cnt", int'(bus.step_cnt), 4095);

      // abort mid-sweep at level 160
      bus.start = 1'b1; bus.y_sel = 2'b10; bus.period = 16'd0;
      tick();
      bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 100; c++) begin
         if (bus.level == 12'd160) begin
            found = 1;
            break;
         end
         tick();
      end
      chk("ab_reach_160", found, 1);
      chk("ab_pre_cnt", int'(bus.step_cnt), 11);
      chk("ab_pre_delta", int'(bus.delta), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("ab_enb", int'(bus.ramp_enb), 0);
      chk("ab_delta", int'(bus.delta), 0);
      chk("ab_busy", int'(bus.busy), 0);
      chk("ab_level", int'(bus.level), 0);
      chk("ab_done", int'(bus.done), 0);
      chk("ab_cnt_frozen", int'(bus.step_cnt), 11);
      dn_seen = 0; d_seen = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         dn_seen += int'(bus.done);
         d_seen  += int'(bus.delta);
      end
      chk("ab_no_done", dn_seen, 0);
      chk("ab_no_delta", d_seen, 0);

      // start together with abort is dropped
      bus.start = 1'b1; bus.abort = 1'b1; bus.y_sel = 2'b11;
      tick();
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("sa_busy", int'(bus.busy), 0);
      chk("sa_enb", int'(bus.ramp_enb), 0);
      tick();
      chk("sa_busy2", int'(bus.busy), 0);
      chk("sa_cnt", int'(bus.step_cnt), 11);

      // zero-step sweep from IDLE
      bus.start = 1'b1; bus.y_sel = 2'b00; bus.period = 16'd5;
      tick();
      bus.start = 1'b0;
      chk("y0_arm_enb", int'(bus.ramp_enb), 1);
      chk("y0_arm_busy", int'(bus.busy), 1);
      chk("y0_arm_done", int'(bus.done), 0);
      tick();
      chk("y0_done", int'(bus.done), 1);
      chk("y0_busy", int'(bus.busy), 0);
      chk("y0_level", int'(bus.level), 0);
      chk("y0_cnt", int'(bus.step_cnt), 0);
      chk("y0_delta", int'(bus.delta), 0);
      tick();
      chk("y0_done_once", int'(bus.done), 0);

      // asynchronous reset mid-strobe
      bus.start = 1'b1; bus.y_sel = 2'b01; bus.period = 16'd0;
      tick();
      bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.delta) begin
            found = 1;
            break;
         end
      end
      chk("rs_strobe_seen", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_enb", int'(bus.ramp_enb), 0);
      chk("rs_delta", int'(bus.delta), 0);
      chk("rs_Y", int'(bus.Y), 0);
      chk("rs_level", int'(bus.level), 0);
      chk("rs_cnt", int'(bus.step_cnt), 0);
      chk("rs_busy", int'(bus.busy), 0);
      chk("rs_done", int'(bus.done), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rs_idle_busy", int'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
